// File: rtl/tpu_pkg.sv
// Shared definitions for the systolic tile datapath: operand width, default
// array size and the operand-feeder FSM state encoding.
package tpu_pkg;

    localparam int DATA_W    = 16;
    localparam int DEFAULT_N = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        STREAM = 2'd2,
        DRAIN  = 2'd3
    } feeder_state_t;

endpackage

// File: rtl/skew_delay_line.sv
// Clear-on-reset shift register of DEPTH stages; DEPTH=0 degenerates to a
// plain wire so lane 0 of the feeder carries no skew.
module skew_delay_line #(
    parameter int DEPTH  = 0,
    parameter int DATA_W = tpu_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] q
);

    generate
        if (DEPTH == 0) begin : g_wire
            logic unused_ctl;
            assign unused_ctl = clk | reset;
            assign q          = d;
        end else begin : g_regs
            logic [DATA_W-1:0] stage [DEPTH];

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    for (int s = 0; s < DEPTH; s++) stage[s] <= '0;
                end else begin
                    stage[0] <= d;
                    for (int s = 1; s < DEPTH; s++) stage[s] <= stage[s-1];
                end
            end

            assign q = stage[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/systolic_operand_feeder.sv
// Buffers up to K_MAX A-column/B-row slices, then streams them diagonally
// skewed into the west and north edges of an N x N PE array, drains, and pulses done.
module systolic_operand_feeder #(
    parameter int N      = tpu_pkg::DEFAULT_N,
    parameter int DATA_W = tpu_pkg::DATA_W,
    parameter int K_MAX  = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [N*DATA_W-1:0] in_a,
    input  logic [N*DATA_W-1:0] in_b,
    input  logic                in_last,
    output logic [N*DATA_W-1:0] a_edge,
    output logic [N*DATA_W-1:0] b_edge,
    output logic                busy,
    output logic                done
);
    import tpu_pkg::*;

    localparam int LANE_W = N * DATA_W;
    localparam int AW     = (K_MAX > 1) ? $clog2(K_MAX) : 1;
    localparam int WR_W   = $clog2(K_MAX + 1);
    localparam int T_W    = $clog2(K_MAX + 2 * N + 1);

    feeder_state_t state, next_state;

    logic [WR_W-1:0]     wr_cnt;
    logic [T_W-1:0]      t_cnt;
    logic [T_W-1:0]      k_ext;
    logic                xfer;
    logic                last_beat;
    logic                stream_end;
    logic                drain_end;
    logic [2*LANE_W-1:0] slice_mem [K_MAX];
    logic [LANE_W-1:0]   inj_a, inj_b;
    logic [LANE_W-1:0]   skew_a, skew_b;

    assign in_ready   = !reset && (state == IDLE || state == LOAD);
    assign xfer       = in_valid && in_ready;
    assign k_ext      = T_W'(wr_cnt);
    // A full buffer closes the tile even without in_last.
    assign last_beat  = in_last || (wr_cnt == WR_W'(K_MAX - 1));
    assign stream_end = (state == STREAM) && (t_cnt == k_ext + T_W'(N - 2));
    assign drain_end  = (state == DRAIN) && (t_cnt == T_W'(2 * N - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // NOTE: every output of this block is given a default first so no latch is inferred.
    always_comb begin
        next_state = state;
        busy       = (state != IDLE);
        done       = 1'b0;
        unique case (state)
            IDLE:   if (xfer) next_state = last_beat ? STREAM : LOAD;
            LOAD:   if (xfer && last_beat) next_state = STREAM;
            STREAM: if (stream_end) next_state = DRAIN;
            DRAIN: begin
                if (drain_end) begin
                    next_state = IDLE;
                    done       = 1'b1;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_cnt <= '0;
            t_cnt  <= '0;
        end else begin
            if (xfer)      wr_cnt <= wr_cnt + 1'b1;
            if (drain_end) wr_cnt <= '0;
            unique case (state)
                STREAM:  t_cnt <= stream_end ? '0 : t_cnt + 1'b1;
                DRAIN:   t_cnt <= drain_end  ? '0 : t_cnt + 1'b1;
                default: t_cnt <= '0;
            endcase
        end
    end

    // NOTE: the slice buffer is deliberately left out of reset; entries are
    // always written before they are read within a tile.
    always_ff @(posedge clk) begin
        if (xfer) slice_mem[wr_cnt[AW-1:0]] <= {in_b, in_a};
    end

    always_comb begin
        {inj_b, inj_a} = '0;
        if (state == STREAM && t_cnt < k_ext)
            {inj_b, inj_a} = slice_mem[t_cnt[AW-1:0]];
    end

    // Lane i of each edge is delayed i cycles so operands meet on the PE diagonal.
    for (genvar i = 0; i < N; i++) begin : g_lane
        skew_delay_line #(.DEPTH(i), .DATA_W(DATA_W)) u_skew_a (
            .clk   (clk),
            .reset (reset),
            .d     (inj_a[i*DATA_W +: DATA_W]),
            .q     (skew_a[i*DATA_W +: DATA_W])
        );
        skew_delay_line #(.DEPTH(i), .DATA_W(DATA_W)) u_skew_b (
            .clk   (clk),
            .reset (reset),
            .d     (inj_b[i*DATA_W +: DATA_W]),
            .q     (skew_b[i*DATA_W +: DATA_W])
        );
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_edge <= '0;
            b_edge <= '0;
        end else begin
            a_edge <= skew_a;
            b_edge <= skew_b;
        end
    end

endmodule

// File: tb/tb_systolic_operand_feeder.sv
// Directed bench for systolic_operand_feeder: per-cycle expected edge values are
// queued when a tile is handed over and compared while the tile streams out.
module tb_systolic_operand_feeder;

    localparam int N      = 4;
    localparam int DATA_W = 16;
    localparam int K_MAX  = 8;
    localparam int LW     = N * DATA_W;

    logic          clk;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [LW-1:0] in_a;
    logic [LW-1:0] in_b;
    logic          in_last;
    logic [LW-1:0] a_edge;
    logic [LW-1:0] b_edge;
    logic          busy;
    logic          done;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [LW-1:0] a;
        logic [LW-1:0] b;
        logic          done;
    } exp_t;

    exp_t sb[$];

    logic [DATA_W-1:0] tile_a [K_MAX][N];
    logic [DATA_W-1:0] tile_b [K_MAX][N];
    int                tile_k;

    systolic_operand_feeder #(.N(N), .DATA_W(DATA_W), .K_MAX(K_MAX)) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_a     (in_a),
        .in_b     (in_b),
        .in_last  (in_last),
        .a_edge   (a_edge),
        .b_edge   (b_edge),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference N x N output-stationary PE array fed from the DUT edges.
    bit                pe_clr;
    logic [DATA_W-1:0] pe_a  [N][N];
    logic [DATA_W-1:0] pe_b  [N][N];
    logic [31:0]       pe_c  [N][N];
    logic [DATA_W-1:0] a_in  [N][N];
    logic [DATA_W-1:0] b_in  [N][N];

    always_comb begin
        for (int i = 0; i < N; i++) begin
            a_in[i][0] = a_edge[i*DATA_W +: DATA_W];
            b_in[0][i] = b_edge[i*DATA_W +: DATA_W];
            for (int j = 1; j < N; j++) begin
                a_in[i][j] = pe_a[i][j-1];
                b_in[j][i] = pe_b[j-1][i];
            end
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                if (pe_clr) begin
                    pe_a[i][j] <= '0;
                    pe_b[i][j] <= '0;
                    pe_c[i][j] <= '0;
                end else begin
                    pe_a[i][j] <= a_in[i][j];
                    pe_b[i][j] <= b_in[i][j];
                    pe_c[i][j] <= pe_c[i][j] + 32'(a_in[i][j]) * 32'(b_in[i][j]);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout required=summary");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [LW-1:0] pack_a(input int k);
        logic [LW-1:0] v = '0;
        for (int i = 0; i < N; i++) v[i*DATA_W +: DATA_W] = tile_a[k][i];
        return v;
    endfunction

    function automatic logic [LW-1:0] pack_b(input int k);
        logic [LW-1:0] v = '0;
        for (int j = 0; j < N; j++) v[j*DATA_W +: DATA_W] = tile_b[k][j];
        return v;
    endfunction

    task automatic fill_tile(input int base);
        for (int k = 0; k < K_MAX; k++) begin
            for (int i = 0; i < N; i++) begin
                tile_a[k][i] = DATA_W'(base + 16 * k + i + 1);
                tile_b[k][i] = DATA_W'(base + 1000 + 16 * k + i + 1);
            end
        end
    endtask

    // Called on the falling edge; ends on the falling edge of the first STREAM cycle.
    task automatic send_tile(input int k, input bit use_last, input bit gaps);
        for (int b = 0; b < k; b++) begin
            check("ready_load", in_ready, 1'b1);
            check("busy_load", busy, b > 0);
            in_valid = 1'b1;
            in_a     = pack_a(b);
            in_b     = pack_b(b);
            in_last  = use_last && (b == k - 1);
            @(negedge clk);
            if (gaps && b < k - 1) begin
                in_valid = 1'b0;
                in_a     = '1;
                in_b     = '1;
                in_last  = 1'b1;
                check("ready_gap", in_ready, 1'b1);
                check("busy_gap", busy, 1'b1);
                @(negedge clk);
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        tile_k   = k;
    endtask

    task automatic push_tile();
        for (int s = 0; s <= tile_k + 3 * N - 2; s++) begin
            exp_t e;
            e.a    = '0;
            e.b    = '0;
            e.done = (s == tile_k + 3 * N - 2);
            for (int i = 0; i < N; i++) begin
                int k = s - i - 1;
                if (k >= 0 && k < tile_k) begin
                    e.a[i*DATA_W +: DATA_W] = tile_a[k][i];
                    e.b[i*DATA_W +: DATA_W] = tile_b[k][i];
                end
            end
            sb.push_back(e);
        end
    endtask

    // Compares every cycle from the first STREAM cycle to the idle cycle after done.
    task automatic run_tile(input bit noise);
        exp_t e;
        push_tile();
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check("a_edge", a_edge, e.a);
            check("b_edge", b_edge, e.b);
            check("done", done, e.done);
            check("busy", busy, 1'b1);
            check("in_ready_tile", in_ready, 1'b0);
            in_valid = noise && (sb.size() > 0);
            in_last  = noise;
            in_a     = {$urandom(), $urandom()};
            in_b     = {$urandom(), $urandom()};
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        check("idle_busy", busy, 1'b0);
        check("idle_ready", in_ready, 1'b1);
        check("idle_done", done, 1'b0);
        check("idle_a_edge", a_edge, '0);
        check("idle_b_edge", b_edge, '0);
    endtask

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_a     = '0;
        in_b     = '0;
        pe_clr   = 1'b1;
        tile_k   = 0;

        @(negedge clk);
        check("rst_ready", in_ready, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_a_edge", a_edge, '0);
        check("rst_b_edge", b_edge, '0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("post_rst_ready", in_ready, 1'b1);
        @(negedge clk);

        // Single-slice tile: lane i carries i+1 on A and i+5 on B.
        for (int i = 0; i < N; i++) begin
            tile_a[0][i] = DATA_W'(i + 1);
            tile_b[0][i] = DATA_W'(i + 5);
        end
        send_tile(1, 1'b1, 1'b0);
        run_tile(1'b0);

        // Full 4x4 product: A = 1..16 row-major, B = identity, so C = A.
        pe_clr = 1'b1;
        for (int k = 0; k < N; k++) begin
            for (int i = 0; i < N; i++) begin
                tile_a[k][i] = DATA_W'(4 * i + k + 1);
                tile_b[k][i] = DATA_W'(k == i);
            end
        end
        @(negedge clk);
        pe_clr = 1'b0;
        send_tile(N, 1'b1, 1'b0);
        run_tile(1'b0);
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                check($sformatf("pe_c_%0d_%0d", i, j), pe_c[i][j], 64'(4 * i + j + 1));

        // Overflow: eight slices without in_last, ninth beat held during the stream.
        fill_tile(100);
        send_tile(K_MAX, 1'b0, 1'b0);
        run_tile(1'b1);

        // Gapped delivery: valid 1,0,1,0,1 with in_last on the third beat.
        fill_tile(300);
        send_tile(3, 1'b1, 1'b1);
        run_tile(1'b0);

        // Reset at stream count t=2 drops the tile without done.
        fill_tile(500);
        send_tile(3, 1'b1, 1'b0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("mid_rst_a_edge", a_edge, '0);
        check("mid_rst_b_edge", b_edge, '0);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_done", done, 1'b0);
        check("mid_rst_ready", in_ready, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("after_rst_ready", in_ready, 1'b1);
        check("after_rst_busy", busy, 1'b0);
        for (int c = 0; c < 3 * N; c++) begin
            @(negedge clk);
            check("after_rst_done", done, 1'b0);
            check("after_rst_a_edge", a_edge, '0);
        end
        fill_tile(700);
        send_tile(2, 1'b1, 1'b0);
        run_tile(1'b0);

        // Back-to-back: the next tile starts in the cycle right after done.
        fill_tile(900);
        send_tile(3, 1'b1, 1'b0);
        run_tile(1'b0);
        fill_tile(1200);
        send_tile(1, 1'b1, 1'b0);
        run_tile(1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
